// File: rtl/wb_trace_buffer_pkg.sv
// wb_trace_buffer_pkg: state encoding and fixed field widths shared by wb_trace_buffer.
// Entry width grows by the stamp field when WB_TRACE_TIMESTAMP_EN is defined.
package wb_trace_buffer_pkg;
  localparam int REG_AW = 5;
  localparam int STAMP_W = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, FROZEN = 2'd2} trace_state_e;
  function automatic int entry_w(input int xlen);
`ifdef WB_TRACE_TIMESTAMP_EN
    return 2 * xlen + REG_AW + STAMP_W;
`else
    return 2 * xlen + REG_AW;
`endif
  endfunction
endpackage

// File: rtl/wb_trace_buffer_trace_ram.sv
// trace_ram: DEPTH x W storage, one synchronous write port and one asynchronous read port.
// Contents are intentionally not reset.
module trace_ram #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: arms on a pulse, records non-x0 writebacks into a FIFO until full or timeout.
// Define WB_TRACE_TIMESTAMP_EN to store the capture cycle count per entry and expose rd_stamp.
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 16,
  parameter int WRAP = 0,
  parameter int TIMEOUT = 100,
  parameter int AW = $clog2(DEPTH),
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              wb_rf_wen,
  input  logic [REG_AW-1:0] wb_write_addr,
  input  logic [XLEN-1:0]   wb_write_value,
  input  logic [XLEN-1:0]   wb_pc,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [XLEN-1:0]   rd_pc,
  output logic [REG_AW-1:0] rd_addr,
  output logic [XLEN-1:0]   rd_value,
`ifdef WB_TRACE_TIMESTAMP_EN
  output logic [STAMP_W-1:0] rd_stamp,
`endif
  output logic [CW-1:0]     count,
  output logic [1:0]        state,
  output logic              overflow,
  output logic              timed_out
);
  localparam int EW = entry_w(XLEN);
  trace_state_e state_q, state_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, to_q, to_d;
  logic cap_ev, full, rd_fire, wen, tmo, drop;
  logic [EW-1:0] wdata, rdata;
  assign cap_ev = state_q == CAPTURE && wb_rf_wen && wb_write_addr != '0;
  assign full = count_q == CW'(DEPTH);
  assign rd_fire = count_q != '0 && rd_ready;
  assign wen = cap_ev && !arm && (!full || rd_fire || WRAP != 0);
  assign drop = cap_ev && full && !rd_fire;
  assign tmo = TIMEOUT != 0 && state_q == CAPTURE && cnt_q == 32'(TIMEOUT - 1);
`ifdef WB_TRACE_TIMESTAMP_EN
  assign wdata = {cnt_q, wb_pc, wb_write_addr, wb_write_value};
  assign rd_stamp = rdata[EW-1 -: STAMP_W];
`else
  assign wdata = {wb_pc, wb_write_addr, wb_write_value};
`endif
  always_comb begin
    state_d = state_q;
    wp_d = wp_q;
    rp_d = rp_q;
    count_d = count_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    to_d = to_q;
    if (arm) begin
      state_d = CAPTURE;
      wp_d = '0;
      rp_d = '0;
      count_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      to_d = 1'b0;
    end else begin
      // a full write without a read in the same cycle overwrites the oldest entry
      rp_d = rp_q + AW'(rd_fire || (wen && full));
      wp_d = wp_q + AW'(wen);
      count_d = count_q + CW'(wen && !full && !rd_fire) - CW'(rd_fire && !wen);
      ovf_d = ovf_q || drop;
      if (state_q == CAPTURE) cnt_d = cnt_q + 32'd1;
      if (tmo) to_d = 1'b1;
      if (tmo || (drop && WRAP == 0)) state_d = FROZEN;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      count_q <= count_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      to_q <= to_d;
    end
  end
  trace_ram #(.W(EW), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .we(wen), .waddr(wp_q), .wdata(wdata), .raddr(rp_q), .rdata(rdata)
  );
  assign rd_valid = count_q != '0;
  assign rd_value = rdata[XLEN-1:0];
  assign rd_addr = rdata[XLEN +: REG_AW];
  assign rd_pc = rdata[XLEN+REG_AW +: XLEN];
  assign count = count_q;
  assign state = state_q;
  assign overflow = ovf_q;
  assign timed_out = to_q;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: two DEPTH=4 instances (freeze with TIMEOUT=10, wrap without timeout) on shared stimulus.
// A queue-based model tracks each instance; directed scenarios precede a randomized run.
module tb_wb_trace_buffer;
  localparam int EW = 69;
  logic clk = 0;
  logic reset = 1;
  logic arm = 0, wb_rf_wen = 0, rd_ready = 0;
  logic [4:0] wb_write_addr = 0;
  logic [31:0] wb_write_value = 0, wb_pc = 0;
  logic rv [2];
  logic [31:0] rpc [2];
  logic [31:0] rval [2];
  logic [4:0] radr [2];
  logic [2:0] cnt [2];
  logic [1:0] st [2];
  logic ovf [2];
  logic tmo [2];
`ifdef WB_TRACE_TIMESTAMP_EN
  logic [31:0] stamp [2];
`endif
  int total = 0, bad = 0;
  logic [EW-1:0] mq [2][$];
  int m_st [2], m_ovf [2], m_to [2], m_cyc [2];
  int m_wrap [2] = '{0, 1};
  int m_tout [2] = '{10, 0};

  always #5 clk = ~clk;

  wb_trace_buffer #(.XLEN(32), .DEPTH(4), .WRAP(0), .TIMEOUT(10)) dut0 (
    .clk(clk), .reset(reset), .arm(arm), .wb_rf_wen(wb_rf_wen), .wb_write_addr(wb_write_addr),
    .wb_write_value(wb_write_value), .wb_pc(wb_pc), .rd_valid(rv[0]), .rd_ready(rd_ready),
    .rd_pc(rpc[0]), .rd_addr(radr[0]), .rd_value(rval[0]),
`ifdef WB_TRACE_TIMESTAMP_EN
    .rd_stamp(stamp[0]),
`endif
    .count(cnt[0]), .state(st[0]), .overflow(ovf[0]), .timed_out(tmo[0]));

  wb_trace_buffer #(.XLEN(32), .DEPTH(4), .WRAP(1), .TIMEOUT(0)) dut1 (
    .clk(clk), .reset(reset), .arm(arm), .wb_rf_wen(wb_rf_wen), .wb_write_addr(wb_write_addr),
    .wb_write_value(wb_write_value), .wb_pc(wb_pc), .rd_valid(rv[1]), .rd_ready(rd_ready),
    .rd_pc(rpc[1]), .rd_addr(radr[1]), .rd_value(rval[1]),
`ifdef WB_TRACE_TIMESTAMP_EN
    .rd_stamp(stamp[1]),
`endif
    .count(cnt[1]), .state(st[1]), .overflow(ovf[1]), .timed_out(tmo[1]));

  task automatic chk(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      m_st[k] = 0;
      m_ovf[k] = 0;
      m_to[k] = 0;
      m_cyc[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    logic ev, rd, expire;
    if (arm) begin
      mq[k].delete();
      m_st[k] = 1;
      m_ovf[k] = 0;
      m_to[k] = 0;
      m_cyc[k] = 0;
      return;
    end
    rd = rd_ready && mq[k].size() > 0;
    ev = m_st[k] == 1 && wb_rf_wen && wb_write_addr != 0;
    expire = m_st[k] == 1 && m_tout[k] != 0 && m_cyc[k] == m_tout[k] - 1;
    if (m_st[k] == 1) m_cyc[k]++;
    if (rd) void'(mq[k].pop_front());
    if (ev) begin
      if (mq[k].size() < 4) mq[k].push_back({wb_pc, wb_write_addr, wb_write_value});
      else if (m_wrap[k] != 0) begin
        void'(mq[k].pop_front());
        mq[k].push_back({wb_pc, wb_write_addr, wb_write_value});
        m_ovf[k] = 1;
      end else begin
        m_ovf[k] = 1;
        m_st[k] = 2;
      end
    end
    if (expire) begin
      m_to[k] = 1;
      m_st[k] = 2;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("state%0d", k), EW'(st[k]), EW'(m_st[k]));
      chk($sformatf("count%0d", k), EW'(cnt[k]), EW'(mq[k].size()));
      chk($sformatf("valid%0d", k), EW'(rv[k]), EW'(mq[k].size() != 0));
      chk($sformatf("overflow%0d", k), EW'(ovf[k]), EW'(m_ovf[k]));
      chk($sformatf("timed_out%0d", k), EW'(tmo[k]), EW'(m_to[k]));
      if (mq[k].size() > 0) chk($sformatf("entry%0d", k), {rpc[k], radr[k], rval[k]}, mq[k][0]);
    end
  endtask

  task automatic cycle(input logic a, input logic w, input logic [4:0] ad, input logic [31:0] v,
                       input logic [31:0] p, input logic r);
    arm = a;
    wb_rf_wen = w;
    wb_write_addr = ad;
    wb_write_value = v;
    wb_pc = p;
    rd_ready = r;
    for (int k = 0; k < 2; k++) model_step(k);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1 reset = 0;
    model_reset();
    @(negedge clk);
    check_all();
    reset = 1;
    // three writes then drain in order
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 32'h11, 32'h100, 0);
    cycle(0, 1, 2, 32'h22, 32'h104, 0);
    cycle(0, 1, 3, 32'h33, 32'h108, 0);
    chk("three_count", EW'(cnt[0]), 3);
    chk("three_first", EW'(rval[0]), 32'h11);
    cycle(0, 1, 0, 32'hDEAD, 32'h10C, 0);
    chk("x0_ignored", EW'(cnt[1]), 3);
    cycle(0, 0, 0, 0, 0, 1);
    chk("drain_second", EW'(rval[1]), 32'h22);
    cycle(0, 0, 0, 0, 0, 1);
    chk("drain_third", EW'(radr[1]), 3);
    cycle(0, 0, 0, 0, 0, 1);
    chk("drained_valid", EW'(rv[1]), 0);
    // six events: freeze instance drops after four, wrap instance keeps the newest four
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      cycle(0, 1, 5'(i), 32'(i), 32'(i * 4), 0);
      if (i == 5) begin
        chk("freeze_count", EW'(cnt[0]), 4);
        chk("freeze_ovf", EW'(ovf[0]), 1);
        chk("freeze_state", EW'(st[0]), 2);
        chk("freeze_oldest", EW'(rval[0]), 1);
      end
    end
    chk("wrap_count", EW'(cnt[1]), 4);
    chk("wrap_ovf", EW'(ovf[1]), 1);
    chk("wrap_state", EW'(st[1]), 1);
    for (int i = 3; i <= 6; i++) begin
      chk("wrap_drain", EW'(rval[1]), EW'(i));
      cycle(0, 0, 0, 0, 0, 1);
    end
    // timeout after ten idle capture cycles, cleared by a new arm
    cycle(1, 0, 0, 0, 0, 0);
    idle(9);
    chk("tmo_before", EW'(tmo[0]), 0);
    idle(1);
    chk("tmo_flag", EW'(tmo[0]), 1);
    chk("tmo_state", EW'(st[0]), 2);
    cycle(1, 0, 0, 0, 0, 0);
    chk("rearm_tmo", EW'(tmo[0]), 0);
    chk("rearm_state", EW'(st[0]), 1);
    // asynchronous reset mid-capture
    cycle(0, 1, 7, 32'h77, 32'h200, 0);
    cycle(0, 1, 8, 32'h88, 32'h204, 0);
    chk("pre_reset_count", EW'(cnt[1]), 2);
    #2 reset = 0;
    #1;
    model_reset();
    chk("async_count", EW'(cnt[1]), 0);
    chk("async_state", EW'(st[1]), 0);
    chk("async_valid", EW'(rv[0]), 0);
    @(negedge clk);
    reset = 1;
    cycle(0, 1, 9, 32'h99, 32'h208, 0);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            $urandom, $urandom, $urandom_range(0, 2) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
